univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal register, the successor of the team's single-bit D flip-flop. It holds a WIDTH-bit word and supports hold, shift-right, shift-left and parallel load, with optional rotate, a clock enable and an asynchronous reset. A bits-remaining counter and an empty flag let it act as a parallel-to-serial converter for the lab's display and serial-output paths.

Parameters:
WIDTH, 8, register width in bits (>=2)
RST_VAL, 0, value loaded into q on reset (WIDTH bits)
CW, $clog2(WIDTH+1), width of the bits-remaining counter (derived; do not override)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  clock enable; 0 = hold all state
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
rotate  input  1  1 = shifts recirculate the bit shifted out instead of using serial inputs
sin_r  input  1  serial input entering the MSB on a right shift
sin_l  input  1  serial input entering the LSB on a left shift
d  input  WIDTH  parallel load data
q  output  WIDTH  register contents (registered)
sout_r  output  1  q[0], the bit leaving on a right shift (combinational from q)
sout_l  output  1  q[WIDTH-1], the bit leaving on a left shift (combinational from q)
bits_left  output  CW  shifts remaining since the last load (registered)
empty  output  1  bits_left == 0 (combinational from bits_left)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high. rst=1 forces q=RST_VAL and bits_left=0 immediately, independent of clk, so empty=1. State is held while rst=1. The first update occurs on the first rising clk edge after rst deasserts.
- Any mode or en change takes effect on the next rising edge. There is one cycle of latency from input to q.
- en=0: q and bits_left hold regardless of mode, rotate, d and serial inputs.
- en=1, mode=00: q and bits_left hold.
- en=1, mode=01 (right):
  - q <= {sin_r, q[WIDTH-1:1]} when rotate=0.
  - q <= {q[0], q[WIDTH-1:1]} when rotate=1.
- en=1, mode=10 (left):
  - q <= {q[WIDTH-2:0], sin_l} when rotate=0.
  - q <= {q[WIDTH-2:0], q[WIDTH-1]} when rotate=1.
- en=1, mode=11: q <= d and bits_left <= WIDTH. rotate and the serial inputs are ignored.
- bits_left on shifts: each shift (mode 01 or 10 with en=1) decrements bits_left by 1 and saturates at 0. Shifting while empty=1 still shifts q; bits_left stays 0.
- Rotate by WIDTH shifts returns q to its original value. bits_left still counts down to 0.
- Serial outputs: sout_r and sout_l always reflect the current q. The bit shifted out on an edge is visible on sout_* before that edge.
- No X propagation: all state has a defined reset value.
- Reset mid-operation (during a shift sequence) aborts it. q=RST_VAL and bits_left=0 on the next sample; no partial shift is committed.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with q=8'hA5 -> q=8'h00, bits_left=0, empty=1 before the next clk edge. Deassert rst -> state holds until the first edge with en=1.
- Load then serialise right: mode=11, d=8'hB4 -> q=8'hB4, bits_left=8. Then 8 edges of mode=01, rotate=0, sin_r=0 -> sout_r sequence before each edge is 0,0,1,0,1,1,0,1. Final q=8'h00, bits_left=0, empty=1.
- Rotate left: load 8'h81, then mode=10, rotate=1 for 1 edge -> q=8'h03. After 8 total edges -> q=8'h81, bits_left=0.
- Shift left with serial input: load 8'h0F, then mode=10, rotate=0, sin_l=1 for 2 edges -> q=8'h3F, bits_left=6.
- Enable gating: load 8'h5A, then en=0 with mode=01 for 3 edges -> q=8'h5A, bits_left=8. Next edge with en=1 -> q=8'h2D (sin_r=0), bits_left=7.
- Saturation: with empty=1 and q=8'h01, mode=01, rotate=1 -> q=8'h80, bits_left stays 0. Then load mid-sequence -> bits_left=8 on the same edge.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold / shift right / shift left / parallel load,
// optional rotate, plus a bits-remaining counter for parallel-to-serial use.
module univ_shift_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter int                 CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    bits_left,
  output logic             empty
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    bl_nxt;
  logic [CW-1:0]    bl_dec;
  logic             in_r;
  logic             in_l;

  // Shifting past empty keeps moving data but the counter pins at zero.
  assign bl_dec = (bits_left == '0) ? '0 : bits_left - CW'(1);
  assign in_r   = rotate ? q[0]       : sin_r;
  assign in_l   = rotate ? q[WIDTH-1] : sin_l;

  always_comb begin
    q_nxt  = q;
    bl_nxt = bits_left;
    if (en) begin
      case (mode)
        MODE_RIGHT: begin
          q_nxt  = {in_r, q[WIDTH-1:1]};
          bl_nxt = bl_dec;
        end
        MODE_LEFT: begin
          q_nxt  = {q[WIDTH-2:0], in_l};
          bl_nxt = bl_dec;
        end
        MODE_LOAD: begin
          q_nxt  = d;
          bl_nxt = CW'(WIDTH);
        end
        default: begin
          q_nxt  = q;
          bl_nxt = bits_left;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= RST_VAL;
      bits_left <= '0;
    end else begin
      q         <= q_nxt;
      bits_left <= bl_nxt;
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  assign empty  = (bits_left == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus pushes hand-computed expected
// state, a negedge monitor pops and compares against the DUT outputs.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          rotate;
  logic          sin_r;
  logic          sin_l;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] bits_left;
  logic          empty;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rotate(rotate),
    .sin_r(sin_r), .sin_l(sin_l), .d(d), .q(q), .sout_r(sout_r),
    .sout_l(sout_l), .bits_left(bits_left), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] bl;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".q"},         32'(q),         32'(e.q));
      chk({e.tag, ".bits_left"}, 32'(bits_left), 32'(e.bl));
      chk({e.tag, ".empty"},     32'(empty),     32'(e.bl == 0));
      chk({e.tag, ".sout_r"},    32'(sout_r),    32'(e.q[0]));
      chk({e.tag, ".sout_l"},    32'(sout_l),    32'(e.q[W-1]));
    end
  end

  task automatic push(input string tag, input logic [W-1:0] eq, input logic [CW-1:0] eb);
    exp_t e;
    e.q = eq; e.bl = eb; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic e_, input logic [1:0] m,
                      input logic rot, input logic sr, input logic sl,
                      input logic [W-1:0] dd, input logic [W-1:0] eq,
                      input logic [CW-1:0] eb);
    @(negedge clk); #1;
    en = e_; mode = m; rotate = rot; sin_r = sr; sin_l = sl; d = dd;
    @(posedge clk); #1;
    push(tag, eq, eb);
  endtask

  // Hand-computed tables
  logic [W-1:0] ser_q [8] = '{8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
  logic [W-1:0] rol_q [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
  logic [W-1:0] ror_q [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; rotate = 1'b0;
    sin_r = 1'b0; sin_l = 1'b0; d = '0;
    #1 push("reset", 8'h00, 4'd0);
    @(negedge clk); #1 rst = 1'b0;

    // Async reset mid-cycle
    step("load_a5", 1, 2'b11, 0, 0, 0, 8'hA5, 8'hA5, 4'd8);
    @(posedge clk); #2 rst = 1'b1;
    #1 push("async_rst", 8'h00, 4'd0);
    step("rst_held", 1, 2'b01, 0, 1, 0, 8'hFF, 8'h00, 4'd0);
    @(negedge clk); #1 en = 1'b0; rst = 1'b0;
    step("en0_after_rst", 0, 2'b11, 0, 0, 0, 8'hFF, 8'h00, 4'd0);
    step("hold_mode", 1, 2'b00, 1, 1, 1, 8'hFF, 8'h00, 4'd0);

    // Load then serialise right
    step("load_b4", 1, 2'b11, 0, 0, 0, 8'hB4, 8'hB4, 4'd8);
    for (int i = 0; i < 8; i++)
      step("ser_right", 1, 2'b01, 0, 0, 0, 8'h00, ser_q[i], CW'(7 - i));

    // Rotate left full circle
    step("load_81", 1, 2'b11, 1, 1, 1, 8'h81, 8'h81, 4'd8);
    for (int i = 0; i < 8; i++)
      step("rot_left", 1, 2'b10, 1, 0, 0, 8'h00, rol_q[i], CW'(7 - i));

    // Shift left with serial input
    step("load_0f", 1, 2'b11, 0, 0, 0, 8'h0F, 8'h0F, 4'd8);
    step("shl_sin1", 1, 2'b10, 0, 0, 1, 8'h00, 8'h1F, 4'd7);
    step("shl_sin1", 1, 2'b10, 0, 0, 1, 8'h00, 8'h3F, 4'd6);

    // Enable gating
    step("load_5a", 1, 2'b11, 0, 0, 0, 8'h5A, 8'h5A, 4'd8);
    for (int i = 0; i < 3; i++)
      step("en_gate", 0, 2'b01, 0, 1, 1, 8'hFF, 8'h5A, 4'd8);
    step("en_resume", 1, 2'b01, 0, 0, 0, 8'h00, 8'h2D, 4'd7);

    // Rotate right to empty, then saturation
    step("load_01", 1, 2'b11, 0, 0, 0, 8'h01, 8'h01, 4'd8);
    for (int i = 0; i < 8; i++)
      step("rot_right", 1, 2'b01, 1, 0, 0, 8'h00, ror_q[i], CW'(7 - i));
    step("sat_rotate", 1, 2'b01, 1, 0, 0, 8'h00, 8'h80, 4'd0);
    step("sat_shift", 1, 2'b01, 0, 1, 0, 8'h00, 8'hC0, 4'd0);
    step("reload_3c", 1, 2'b11, 0, 1, 1, 8'h3C, 8'h3C, 4'd8);
    step("after_reload", 1, 2'b01, 0, 1, 0, 8'h00, 8'h9E, 4'd7);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
